modbus_rtu_tx: RTL

- Transmit end of the Modbus RTU serial link, paired with the UART receiver that feeds ModbusToWishbone.
- Pops 9-bit words from the response FIFO that ModbusToWishbone writes into.
- Serialises data words as Modbus RTU characters: 1 start bit, 8 data bits LSB first, parity or extra stop bit, stop bit.
- Marker words (bit 8 set) produce the ≥3.5-character inter-frame silence. Drives an RS-485 driver-enable output.

---
 rtl/modbus_rtu_tx.sv | 115 +++++++++++
 1 files changed

// File: rtl/modbus_rtu_tx.sv
// modbus_rtu_tx: Modbus RTU character transmitter with RS-485 driver enable.
// MODBUS_TX_PARITY_EN selects 8E1 characters; the default build sends 8N2.
module modbus_rtu_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int SILENCE_BITS = 39
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       empty,
  output logic       readReq,
  input  logic       readAck,
  input  logic [8:0] dataIn,
  output logic       tx,
  output logic       txEnable,
  output logic       busy
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int NW = $clog2(SILENCE_BITS > 8 ? SILENCE_BITS : 8);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] SIL_LAST = NW'(SILENCE_BITS - 1);
  localparam logic [NW-1:0] DATA_LAST = NW'(7);
`ifdef MODBUS_TX_PARITY_EN
  localparam logic [NW-1:0] STOP_LAST = '0;
  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP, SILENCE, PAR} state_t;
  localparam state_t AFTER_DATA = PAR;
`else
  localparam logic [NW-1:0] STOP_LAST = NW'(1);
  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP, SILENCE} state_t;
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state_q;
  logic [BW-1:0] baud_q, baud_d;
  logic [NW-1:0] bit_q;
  logic [7:0] shift_q;
  logic pad_q;
  logic tick;
  always_comb begin
    tick = baud_q == BAUD_LAST;
    baud_d = tick ? '0 : baud_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SILENCE;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      pad_q <= 1'b1;
      readReq <= 1'b0;
      tx <= 1'b1;
      txEnable <= 1'b0;
      busy <= 1'b1;
    end else begin
      baud_q <= (state_q == IDLE || state_q == FETCH) ? '0 : baud_d;
      case (state_q)
        IDLE:
          if (!empty) begin
            state_q <= FETCH;
            busy <= 1'b1;
          end
        // request goes out one cycle after entering FETCH, so it never overlaps a capture edge
        FETCH:
          if (readReq && readAck) begin
            readReq <= 1'b0;
            shift_q <= dataIn[7:0];
`ifdef MODBUS_TX_PARITY_EN
            pad_q <= ^dataIn[7:0];
`else
            pad_q <= 1'b1;
`endif
            bit_q <= '0;
            state_q <= dataIn[8] ? SILENCE : START;
            tx <= dataIn[8];
            txEnable <= !dataIn[8];
          end else readReq <= 1'b1;
        START:
          if (tick) begin
            state_q <= DATA;
            tx <= shift_q[0];
          end
        DATA:
          if (tick) begin
            shift_q <= shift_q >> 1;
            bit_q <= bit_q == DATA_LAST ? '0 : bit_q + 1'b1;
            state_q <= bit_q == DATA_LAST ? AFTER_DATA : DATA;
            tx <= bit_q == DATA_LAST ? pad_q : shift_q[1];
          end
`ifdef MODBUS_TX_PARITY_EN
        PAR:
          if (tick) begin
            state_q <= STOP;
            tx <= 1'b1;
          end
`endif
        STOP:
          if (tick) begin
            bit_q <= bit_q == STOP_LAST ? '0 : bit_q + 1'b1;
            if (bit_q == STOP_LAST) begin
              state_q <= empty ? IDLE : FETCH;
              txEnable <= !empty;
              busy <= !empty;
            end
          end
        SILENCE:
          if (tick) begin
            bit_q <= bit_q == SIL_LAST ? '0 : bit_q + 1'b1;
            if (bit_q == SIL_LAST) begin
              state_q <= empty ? IDLE : FETCH;
              busy <= !empty;
            end
          end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
